// File: rtl/core_pkg.sv
// Shared types for the memory-port arbiter: FSM states, transaction owner, core width.
package core_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    IFU,
    LSU
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU.
// LSU has priority unless the IFU has been passed over MAX_WAIT times in a row.
module mem_arb_pick
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             ifu_valid,
  input  logic             lsu_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  output owner_t           winner
);

  logic ifu_starved;

  always_comb begin
    ifu_starved = ifu_valid && (starve_cnt == CNT_W'(MAX_WAIT));
    winner      = NONE;
    if (lsu_valid && !ifu_starved) begin
      winner = LSU;
    end else if (ifu_valid) begin
      winner = IFU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bridge port between instruction fetch and load/store, one transaction
// in flight; the response pulse is routed back to whichever side owns the transaction.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W   = XLEN,
  parameter int DATA_W   = XLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_WAIT + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  owner_t            winner;
  logic              rsp_fire;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .starve_cnt (starve_q),
    .winner     (winner)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_d      = starve_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        ifu_req_ready = (winner == IFU);
        lsu_req_ready = (winner == LSU);
        if (winner == LSU) begin
          owner_d = LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          // Loads carry no store payload to the bridge.
          wdata_d = lsu_wen ? lsu_wdata : '0;
          wmask_d = lsu_wen ? lsu_wmask : '0;
          if (ifu_req_valid && (starve_q != CNT_W'(MAX_WAIT))) begin
            starve_d = starve_q + CNT_W'(1);
          end
          state_d = REQ;
        end else if (winner == IFU) begin
          owner_d  = IFU;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          starve_d = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          owner_d  = NONE;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  always_comb begin
    ifu_rsp_valid = rsp_fire && (owner_q == IFU);
    lsu_rsp_valid = rsp_fire && (owner_q == LSU);
    ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
    lsu_rdata     = (lsu_rsp_valid && !wen_q) ? mem_rdata : '0;
    mem_addr      = addr_q;
    mem_wen       = wen_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= NONE;
      starve_q <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus hand-written
// sequences for starvation, reset mid-transaction and spurious bridge responses.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [63:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_addr;
  logic        lsu_wen;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W   (64),
    .DATA_W   (64),
    .MAX_WAIT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ifu_v;
    logic [63:0] ifu_a;
    logic        lsu_v;
    logic [63:0] lsu_a;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          stall;
    logic [63:0] rdata;
    logic        e_ifu_rdy;
    logic        e_lsu_rdy;
    logic [63:0] e_addr;
    logic        e_wen;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata;
    logic        e_ifu_rsp;
    logic [63:0] e_ifu_rdata;
    logic        e_lsu_rsp;
    logic [63:0] e_lsu_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one transaction from IDLE; returns with the response on the bus in WAIT_RSP.
  // mem_rsp_valid is left high into the next IDLE cycle, where it must be ignored.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ifu_req_valid = v.ifu_v;
    ifu_addr      = v.ifu_a;
    lsu_req_valid = v.lsu_v;
    lsu_addr      = v.lsu_a;
    lsu_wen       = v.wen;
    lsu_wdata     = v.wdata;
    lsu_wmask     = v.wmask;
    mem_req_ready = 1'b0;
    #1;
    chk("idle_ifu_rsp", {63'd0, ifu_rsp_valid}, 64'd0);
    chk("idle_lsu_rsp", {63'd0, lsu_rsp_valid}, 64'd0);
    chk("ifu_ready", {63'd0, ifu_req_ready}, {63'd0, v.e_ifu_rdy});
    chk("lsu_ready", {63'd0, lsu_req_ready}, {63'd0, v.e_lsu_rdy});
    chk("idle_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    @(negedge clk);
    for (int s = 0; s <= v.stall; s++) begin
      chk("req_mem_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("req_mem_addr", mem_addr, v.e_addr);
      chk("req_mem_wen", {63'd0, mem_wen}, {63'd0, v.e_wen});
      chk("req_mem_wmask", {56'd0, mem_wmask}, {56'd0, v.e_wmask});
      if (v.e_wen) chk("req_mem_wdata", mem_wdata, v.e_wdata);
      chk("req_ready_low", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      if (s == v.stall) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    #1;
    chk("wait_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("wait_no_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = v.rdata;
    #1;
    chk("ifu_rsp_valid", {63'd0, ifu_rsp_valid}, {63'd0, v.e_ifu_rsp});
    chk("ifu_rdata", ifu_rdata, v.e_ifu_rdata);
    chk("lsu_rsp_valid", {63'd0, lsu_rsp_valid}, {63'd0, v.e_lsu_rsp});
    chk("lsu_rdata", lsu_rdata, v.e_lsu_rdata);
  endtask

  vec_t vecs [5];
  vec_t sv;

  initial begin
    rst           = 1'b0;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    // IFU-only fetch, answered at once
    vecs[0] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 0, 64'h13,
                1'b1, 1'b0, 64'h8000_0000, 1'b0, 8'h00, 64'h0,
                1'b1, 64'h13, 1'b0, 64'h0};
    // both valid, counter at 0: LSU load wins
    vecs[1] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_0100, 1'b0, 64'h0, 8'h00, 1, 64'h1122_3344_5566_7788,
                1'b0, 1'b1, 64'h8000_0100, 1'b0, 8'h00, 64'h0,
                1'b0, 64'h0, 1'b1, 64'h1122_3344_5566_7788};
    // the waiting IFU gets the next IDLE
    vecs[2] = '{1'b1, 64'h8000_0004, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 0, 64'h0000_0013_0000_0093,
                1'b1, 1'b0, 64'h8000_0004, 1'b0, 8'h00, 64'h0,
                1'b1, 64'h0000_0013_0000_0093, 1'b0, 64'h0};
    // store with a 3-cycle bridge stall; store ack returns rdata 0
    vecs[3] = '{1'b0, 64'h0, 1'b1, 64'h8000_0008, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 64'h55,
                1'b0, 1'b1, 64'h8000_0008, 1'b1, 8'h0F, 64'hDEAD_BEEF,
                1'b0, 64'h0, 1'b1, 64'h0};
    // load with a stray mask on the input: mask must not reach the bridge
    vecs[4] = '{1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b0, 64'hCAFE, 8'hFF, 0, 64'hA5A5,
                1'b0, 1'b1, 64'h8000_0010, 1'b0, 8'h00, 64'h0,
                1'b0, 64'h0, 1'b1, 64'hA5A5};

    @(negedge clk);
    #1;
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    chk("rst_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Starvation: both valid every IDLE; 4 LSU grants, then IFU, then LSU again
    for (int i = 0; i < 6; i++) begin
      sv = vecs[1];
      sv.lsu_a = 64'h8000_0200 + 64'(i * 8);
      sv.ifu_a = 64'h8000_1000;
      sv.stall = 0;
      sv.rdata = 64'h100 + 64'(i);
      if (i == 4) begin
        sv.e_ifu_rdy = 1'b1; sv.e_lsu_rdy = 1'b0; sv.e_addr = 64'h8000_1000;
        sv.e_ifu_rsp = 1'b1; sv.e_ifu_rdata = 64'h104;
        sv.e_lsu_rsp = 1'b0; sv.e_lsu_rdata = 64'h0;
      end else begin
        sv.e_ifu_rdy = 1'b0; sv.e_lsu_rdy = 1'b1; sv.e_addr = 64'h8000_0200 + 64'(i * 8);
        sv.e_ifu_rsp = 1'b0; sv.e_ifu_rdata = 64'h0;
        sv.e_lsu_rsp = 1'b1; sv.e_lsu_rdata = 64'h100 + 64'(i);
      end
      run_vec(sv);
    end

    // Response coinciding with mem_req_ready is ignored; then reset in WAIT_RSP
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_2000;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h99;
    #1;
    chk("req_rsp_same_cycle", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    chk("req_rsp_rdata", ifu_rdata, 64'd0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    chk("still_waiting", {62'd0, ifu_rsp_valid, mem_req_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h77;
    #1;
    chk("late_rsp_ifu", {63'd0, ifu_rsp_valid}, 64'd0);
    chk("late_rsp_rdata", ifu_rdata, 64'd0);
    chk("late_rsp_lsu", {63'd0, lsu_rsp_valid}, 64'd0);
    run_vec(vecs[4]);

    // Spurious response in IDLE with no requesters
    @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFF;
    #1;
    chk("spur_rsp", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
    chk("spur_rdata", ifu_rdata | lsu_rdata, 64'd0);
    chk("spur_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    run_vec(vecs[0]);

    @(negedge clk);
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
